// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants, legal modulus range and binary-to-two-digit-BCD helper
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int MOD_MIN = 2;
  localparam int MOD_MAX = 100;
  function automatic logic [7:0] bin2bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register (clk,rst,init,lim,set,set_val,inc,dec -> q,at_max,at_min); inc/dec wrap between 0 and lim
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] init,
  input  logic [3:0] lim,
  input  logic       set,
  input  logic [3:0] set_val,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);
  assign at_max = q == lim;
  assign at_min = q == 4'd0;
  always_ff @(posedge clk)
    if (rst) q <= init;
    else if (set) q <= set_val;
    else if (inc) q <= at_max ? 4'd0 : q + 4'd1;
    else if (dec) q <= at_min ? lim : q - 4'd1;
endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD modulo-MOD counter (clk,rst,tick_in,up_dn,load,load_tens,load_ones -> tens,ones,carry_out,tc,load_err); down-count enabled by BCD_CNT_DOWN_EN
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int MOD      = 60,
  parameter int INIT_VAL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       up_dn,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out,
  output logic       tc,
  output logic       load_err
);
  localparam logic [7:0] MAX_BCD  = bin2bcd2(MOD - 1);
  localparam logic [7:0] INIT_BCD = bin2bcd2(INIT_VAL);
  localparam logic [3:0] T_MAX    = MAX_BCD[7:4];
  localparam logic [3:0] O_MAX    = MAX_BCD[3:0];
  generate
    if (MOD < MOD_MIN || MOD > MOD_MAX || INIT_VAL < 0 || INIT_VAL >= MOD) begin : g_bad_param
      $error("bcd_mod_counter: MOD must be 2..100 and INIT_VAL 0..MOD-1");
    end
  endgenerate
  function automatic logic in_range(input logic [3:0] t, input logic [3:0] o);
    return o <= BCD_MAX && (t < T_MAX || (t == T_MAX && o <= O_MAX));
  endfunction
  logic down, legal, load_ok, at_top, at_bot, wrap, set;
  logic [3:0] set_t, set_o;
  logic t_max, t_min, o_max, o_min;
`ifdef BCD_CNT_DOWN_EN
  assign down = !up_dn;
`else
  assign down = up_dn & 1'b0;
`endif
  always_comb begin
    legal     = in_range(tens, ones);
    load_ok   = in_range(load_tens, load_ones);
    at_top    = t_max && ones == O_MAX;
    at_bot    = t_min && o_min;
    wrap      = down ? at_bot : at_top;
    tc        = wrap;
    carry_out = !rst && !load && tick_in && wrap;
    set       = load || (tick_in && (!legal || wrap));
    set_t     = load ? (load_ok ? load_tens : 4'd0) : (legal && down && at_bot ? T_MAX : 4'd0);
    set_o     = load ? (load_ok ? load_ones : 4'd0) : (legal && down && at_bot ? O_MAX : 4'd0);
  end
  bcd_digit u_tens (
    .clk(clk), .rst(rst), .init(INIT_BCD[7:4]), .lim(T_MAX),
    .set(set), .set_val(set_t),
    .inc(tick_in && !down && o_max), .dec(tick_in && down && o_min),
    .q(tens), .at_max(t_max), .at_min(t_min)
  );
  bcd_digit u_ones (
    .clk(clk), .rst(rst), .init(INIT_BCD[3:0]), .lim(BCD_MAX),
    .set(set), .set_val(set_o),
    .inc(tick_in && !down), .dec(tick_in && down),
    .q(ones), .at_max(o_max), .at_min(o_min)
  );
  always_ff @(posedge clk)
    load_err <= rst ? 1'b0 : load && !load_ok;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: scoreboard bench with integer reference model for MOD=60/24 counters and a 60/60/24 cascade
module tb_bcd_mod_counter;
  typedef struct {
    logic co;
    logic tc;
    int   tens;
    int   ones;
    logic err;
  } exp_t;
  logic clk = 0;
  logic rst, load, tick_in, up_dn;
  logic [3:0] load_tens, load_ones;
  logic [3:0] a_tens, a_ones, b_tens, b_ones;
  logic a_co, a_tc, a_err, b_co, b_tc, b_err;
  logic crst, ctick, cdone;
  logic [3:0] s_tens, s_ones, m_tens, m_ones, h_tens, h_ones;
  logic s_co, m_co, h_co, s_tc, m_tc, h_tc, s_err, m_err, h_err;
  int total = 0, bad = 0;
  int va = 0, vb = 5;
  exp_t qa[$], qb[$];
  always #5 clk = ~clk;
  bcd_mod_counter #(.MOD(60), .INIT_VAL(0)) u_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .up_dn(up_dn), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .tens(a_tens), .ones(a_ones),
    .carry_out(a_co), .tc(a_tc), .load_err(a_err)
  );
  bcd_mod_counter #(.MOD(24), .INIT_VAL(5)) u_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .up_dn(up_dn), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .tens(b_tens), .ones(b_ones),
    .carry_out(b_co), .tc(b_tc), .load_err(b_err)
  );
  bcd_mod_counter #(.MOD(60), .INIT_VAL(59)) u_s (
    .clk(clk), .rst(crst), .tick_in(ctick), .up_dn(1'b1), .load(1'b0),
    .load_tens(4'd0), .load_ones(4'd0), .tens(s_tens), .ones(s_ones),
    .carry_out(s_co), .tc(s_tc), .load_err(s_err)
  );
  bcd_mod_counter #(.MOD(60), .INIT_VAL(59)) u_m (
    .clk(clk), .rst(crst), .tick_in(s_co), .up_dn(1'b1), .load(1'b0),
    .load_tens(4'd0), .load_ones(4'd0), .tens(m_tens), .ones(m_ones),
    .carry_out(m_co), .tc(m_tc), .load_err(m_err)
  );
  bcd_mod_counter #(.MOD(24), .INIT_VAL(23)) u_h (
    .clk(clk), .rst(crst), .tick_in(m_co), .up_dn(1'b1), .load(1'b0),
    .load_tens(4'd0), .load_ones(4'd0), .tens(h_tens), .ones(h_ones),
    .carry_out(h_co), .tc(h_tc), .load_err(h_err)
  );
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step(input int mod, input int init, input bit r, input bit ld, input bit tk,
                      input bit ud, input int lt, input int lo, inout int v, output exp_t e);
    bit down, ok;
    int lv;
`ifdef BCD_CNT_DOWN_EN
    down = !ud;
`else
    down = ud & 1'b0;
`endif
    e.tc = down ? v == 0 : v == mod - 1;
    e.co = 0;
    e.err = 0;
    lv = lt * 10 + lo;
    ok = lt <= 9 && lo <= 9 && lv < mod;
    if (r) v = init;
    else if (ld) begin
      v = ok ? lv : 0;
      e.err = !ok;
    end else if (tk) begin
      e.co = down ? v == 0 : v == mod - 1;
      v = down ? (v + mod - 1) % mod : (v + 1) % mod;
    end
    e.tens = v / 10;
    e.ones = v % 10;
  endtask
  task automatic drive(input bit r, input bit ld, input bit tk, input bit ud, input int lt, input int lo);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; tick_in = tk; up_dn = ud;
    load_tens = 4'(lt); load_ones = 4'(lo);
    step(60, 0, r, ld, tk, ud, lt, lo, va, e);
    qa.push_back(e);
    step(24, 5, r, ld, tk, ud, lt, lo, vb, e);
    qb.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_carry", int'(a_co), int'(e.co));
        chk("a_tc", int'(a_tc), int'(e.tc));
        @(posedge clk);
        #1;
        chk("a_tens", int'(a_tens), e.tens);
        chk("a_ones", int'(a_ones), e.ones);
        chk("a_load_err", int'(a_err), int'(e.err));
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_carry", int'(b_co), int'(e.co));
        chk("b_tc", int'(b_tc), int'(e.tc));
        @(posedge clk);
        #1;
        chk("b_tens", int'(b_tens), e.tens);
        chk("b_ones", int'(b_ones), e.ones);
        chk("b_load_err", int'(b_err), int'(e.err));
      end
    end
  end
  initial begin
    cdone = 0; crst = 1; ctick = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("casc_init_h", int'({h_tens, h_ones}), 8'h23);
    chk("casc_init_m", int'({m_tens, m_ones}), 8'h59);
    chk("casc_init_s", int'({s_tens, s_ones}), 8'h59);
    chk("casc_rst_carry", int'(h_co), 0);
    @(negedge clk);
    crst = 0; ctick = 1;
    #2;
    chk("casc_h_tc", int'(h_tc), 1);
    chk("casc_s_carry", int'(s_co), 1);
    chk("casc_m_carry", int'(m_co), 1);
    chk("casc_h_carry", int'(h_co), 1);
    @(posedge clk);
    #1;
    chk("casc_wrap", int'({h_tens, h_ones, m_tens, m_ones, s_tens, s_ones}), 0);
    @(negedge clk);
    crst = 1; ctick = 1;
    #2;
    chk("casc_rst_tick_carry", int'(s_co), 0);
    @(posedge clk);
    #1;
    chk("casc_rst_tick_val", int'({h_tens, h_ones, m_tens, m_ones, s_tens, s_ones}), 24'h235959);
    chk("casc_load_err", int'({s_err, m_err, h_err}), 0);
    @(negedge clk);
    crst = 0; ctick = 0;
    cdone = 1;
  end
  initial begin
    rst = 1; load = 0; tick_in = 0; up_dn = 1; load_tens = 0; load_ones = 0;
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0, 0);
    repeat (60) drive(0, 0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 2, 3);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 2, 4);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 1, 3, 5);
    drive(0, 1, 1, 1, 4, 2);
    drive(1, 0, 1, 1, 0, 0);
    drive(0, 1, 0, 1, 9, 9);
    drive(0, 1, 0, 1, 5, 12);
`ifdef BCD_CNT_DOWN_EN
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    repeat (3) drive(0, 0, 1, 0, 0, 0);
`else
    drive(0, 1, 0, 1, 1, 0);
    repeat (3) drive(0, 0, 1, 0, 0, 0);
`endif
    repeat (400) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9)),
            $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9)));
    end
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 30 && (qa.size() > 0 || qb.size() > 0 || !cdone); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (qa.size() > 0 || qb.size() > 0 || !cdone) begin
      bad++;
      $display("FAIL drain_timeout: qa=%0d qb=%0d cascade_done=%0d", qa.size(), qb.size(), cdone);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
